// File: rtl/regfile_sweep.sv
// ---------------------------------------------------------------------------
// regfile_sweep
//
// Parametrised MIPS-style general register file with a hardware clear-sweep
// engine. Register 0 is hardwired to zero. Reads are purely combinational on
// NUM_RD independent ports. Writes land on the rising clock edge while the
// sweep engine is idle. A one-cycle clear_start pulse launches a sweep. The
// sweep zeroes registers 1..DEPTH-1, one per cycle, and then pulses done.
//
// Configuration macro:
//   REGF_BYPASS_EN  - when defined, a write in flight (we=1, engine idle,
//                     wa!=0) is forwarded combinationally to any read port
//                     whose address matches wa. When undefined, reads return
//                     the stored value until the clock edge.
//
// Parameters:
//   DATA_WIDTH  register width in bits
//   ADDR_WIDTH  register address width (>= 2); DEPTH = 2**ADDR_WIDTH
//   NUM_RD      number of combinational read ports (1..4)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-high reset: clears every register,
//                returns the engine to idle
//   we/wa/wd     write enable / address / data
//   ra           flattened read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rd           flattened read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   clear_start  one-cycle request to begin a clear sweep
//   busy         high while the sweep engine is active (SWEEP or DONE)
//   done         one-cycle pulse on the cycle after the last register clears
// ---------------------------------------------------------------------------
module regfile_sweep #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        wa,
    input  logic [DATA_WIDTH-1:0]        wd,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd,
    input  logic                         clear_start,
    output logic                         busy,
    output logic                         done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    // All-ones address equals DEPTH-1, the last register the sweep clears.
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SWEEP = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [ADDR_WIDTH-1:0]  cnt_r;
    logic [ADDR_WIDTH-1:0]  cnt_s;
    logic                   busy_r;
    logic                   busy_s;
    logic                   done_r;
    logic                   done_s;
    logic                   wr_en_s;
    logic                   clr_en_s;

    // Entry 0 exists only to keep indexing simple. Nothing ever writes it,
    // and the read muxes mask it to zero.
    logic [DATA_WIDTH-1:0]  mem_r [DEPTH];

    // Sweep FSM state, sweep counter and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= ADDR_ONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state and next-counter logic for the sweep engine.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = ADDR_ONE;
                if (clear_start) begin
                    state_s = ST_SWEEP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                // The terminal compare is on DEPTH-1, so the counter never
                // wraps onto register 0.
                if (cnt_r == ADDR_LAST) begin
                    state_s = ST_DONE;
                    cnt_s   = ADDR_ONE;
                end else begin
                    state_s = ST_SWEEP;
                    cnt_s   = cnt_r + ADDR_ONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = ADDR_ONE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = ADDR_ONE;
            end
        endcase
    end

    // Output and datapath-enable decode. Status outputs are computed from
    // the next state so the registered copies track the state register.
    always_comb begin
        busy_s   = (state_s != ST_IDLE);
        done_s   = (state_s == ST_DONE);
        // External writes are dropped outright while the engine is busy.
        wr_en_s  = we && (state_r == ST_IDLE) && (wa != ADDR_ZERO);
        clr_en_s = (state_r == ST_SWEEP);
    end

    assign busy = busy_r;
    assign done = done_r;

    // Register storage: async clear on reset, otherwise a write or a sweep
    // clear. The two cannot coincide because writes happen only in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DATA_ZERO;
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wa] <= wd;
            end
            if (clr_en_s) begin
                mem_r[cnt_r] <= DATA_ZERO;
            end
        end
    end

    // Combinational read ports.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr_s;
        logic [DATA_WIDTH-1:0] data_s;

        assign addr_s = ra[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Read mux for this port. Register 0 is forced to zero; the optional
        // forwarding path returns the in-flight write data.
        always_comb begin
            if (addr_s == ADDR_ZERO) begin
                data_s = DATA_ZERO;
`ifdef REGF_BYPASS_EN
            end else if (wr_en_s && (wa == addr_s)) begin
                data_s = wd;
`endif
            end else begin
                data_s = mem_r[addr_s];
            end
        end

        assign rd[k*DATA_WIDTH +: DATA_WIDTH] = data_s;
    end

endmodule
